// File: rtl/clk_div_period_meter.sv
// Measures rising-edge period of sig_i in clk_i cycles, flags errors/timeouts, tracks lock; optional CLK_DIV_PERIOD_METER_SYNC_EN.
// Latency: period_valid_o 2 cycles after a sig_i rising edge (+2 with sync); no backpressure, pulses are one cycle.
module clk_div_period_meter #(
  parameter int CNT_WIDTH  = 16,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] div_i,
  input  logic                 sig_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 err_o,
  output logic                 timeout_o,
  output logic                 lock_o,
  output logic [7:0]           err_cnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam int LOCK_TGT = (LOCK_COUNT < 1) ? 1 : LOCK_COUNT;
  localparam int MW       = $clog2(LOCK_TGT + 1);
  localparam int XW       = CNT_WIDTH + 2;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] div_q;
  logic [MW-1:0]        match_cnt;
  logic                 sig_in;
  logic                 sig_s;
  logic                 sig_prev;

`ifdef CLK_DIV_PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], sig_i};
  end

  assign sig_in = sync_q[1];
`else
  assign sig_in = sig_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_s    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_s    <= sig_in;
      sig_prev <= sig_s;
    end
  end

  logic          rise;
  logic          div_ok;
  logic          div_chg;
  logic [XW-1:0] cnt_x;
  logic [XW-1:0] div_x;
  logic [XW-1:0] tol_x;
  logic [XW-1:0] limit;
  logic [XW-1:0] diff;
  logic          in_tol;
  logic          timeout_hit;

  assign rise    = sig_s & ~sig_prev;
  assign div_ok  = div_i > CNT_WIDTH'(1);
  assign div_chg = div_i != div_q;
  assign cnt_x   = {2'b00, cnt};
  assign div_x   = {2'b00, div_i};
  assign tol_x   = XW'(TOLERANCE);
  assign limit   = div_x + tol_x + XW'(1);
  assign diff    = (cnt_x >= div_x) ? (cnt_x - div_x) : (div_x - cnt_x);
  assign in_tol  = diff <= tol_x;
  // A saturated counter also times out, covering limits wider than CNT_WIDTH.
  assign timeout_hit = (cnt_x >= limit) || (&cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      div_q          <= '0;
      match_cnt      <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      err_o          <= 1'b0;
      timeout_o      <= 1'b0;
      lock_o         <= 1'b0;
      err_cnt_o      <= 8'd0;
    end else begin
      period_valid_o <= 1'b0;
      err_o          <= 1'b0;
      timeout_o      <= 1'b0;
      div_q          <= div_i;

      if (!en_i) begin
        state     <= IDLE;
        lock_o    <= 1'b0;
        match_cnt <= '0;
      end else if (state != IDLE && div_chg) begin
        state     <= ARM;
        lock_o    <= 1'b0;
        match_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div_ok) state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= CNT_WIDTH'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_o       <= cnt;
              period_valid_o <= 1'b1;
              cnt            <= CNT_WIDTH'(1);
              if (!in_tol) begin
                err_o     <= 1'b1;
                lock_o    <= 1'b0;
                match_cnt <= '0;
                if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
              end else begin
                if (match_cnt < MW'(LOCK_TGT)) match_cnt <= match_cnt + MW'(1);
                if (match_cnt >= MW'(LOCK_TGT - 1)) lock_o <= 1'b1;
              end
            end else if (timeout_hit) begin
              timeout_o <= 1'b1;
              lock_o    <= 1'b0;
              match_cnt <= '0;
              state     <= ARM;
              if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            end else if (!(&cnt)) begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_period_meter.sv
// Scoreboarded bench for clk_div_period_meter (default build, TOLERANCE=0, LOCK_COUNT=4).
module tb_clk_div_period_meter;

  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic [W-1:0] div_i;
  logic         sig_i;
  logic [W-1:0] period_o;
  logic         period_valid_o;
  logic         err_o;
  logic         timeout_o;
  logic         lock_o;
  logic [7:0]   err_cnt_o;

  always #5 clk = ~clk;

  clk_div_period_meter #(.CNT_WIDTH(W), .TOLERANCE(0), .LOCK_COUNT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .div_i          (div_i),
    .sig_i          (sig_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .err_o          (err_o),
    .timeout_o      (timeout_o),
    .lock_o         (lock_o),
    .err_cnt_o      (err_cnt_o)
  );

  typedef struct {
    bit to;
    int per;
    bit err;
    bit lock;
    int gap;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_evt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_i && (period_valid_o || timeout_o || err_o)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b err=%0b timeout=%0b period=%0d, expected no event",
                 period_valid_o, err_o, timeout_o, period_o);
      end else begin
        e = q.pop_front();
        chk("evt_timeout_o", timeout_o, e.to);
        chk("evt_period_valid_o", period_valid_o, !e.to);
        if (!e.to) begin
          chk("evt_period_o", period_o, e.per);
          chk("evt_err_o", err_o, e.err);
        end
        chk("evt_lock_o", lock_o, e.lock);
        if (e.gap >= 0) chk("evt_gap", cyc - last_evt, e.gap);
      end
      last_evt = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic one_period(input int p);
    int h;
    h = p / 2;
    for (int i = 0; i < p; i++) begin
      sig_i = (i < h);
      tick(1);
    end
  endtask

  task automatic run_calls(input int p, input int n);
    for (int i = 0; i < n; i++) one_period(p);
  endtask

  task automatic pv(input int per, input bit err, input bit lock, input int gap);
    exp_t x;
    x.to = 1'b0; x.per = per; x.err = err; x.lock = lock; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic pt(input int gap);
    exp_t x;
    x.to = 1'b1; x.per = 0; x.err = 1'b0; x.lock = 1'b0; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int p2[10] = '{8, 8, 8, 8, 9, 8, 8, 8, 8, 8};
  int dv[2]  = '{0, 1};

  initial begin
    rst_i = 1'b1; en_i = 1'b0; div_i = '0; sig_i = 1'b0;
    tick(3);
    chk("rst_period_o", period_o, 0);
    chk("rst_period_valid_o", period_valid_o, 0);
    chk("rst_lock_o", lock_o, 0);
    chk("rst_err_cnt_o", err_cnt_o, 0);
    chk("rst_state", dut.state, S_IDLE);
    rst_i = 1'b0;

    // Ideal divide-by-5 for 20 measured periods.
    div_i = 5; en_i = 1'b1; tick(3);
    for (int j = 1; j <= 20; j++) pv(5, 0, j >= 4, (j == 1) ? -1 : 5);
    run_calls(5, 21);
    chk("t1_lock_o", lock_o, 1);
    en_i = 1'b0; tick(3);
    chk("t1_pending", q.size(), 0);
    chk("t1_err_cnt_o", err_cnt_o, 0);
    chk("t1_period_hold", period_o, 5);

    // One stretched period of 9 at div 8.
    do_reset();
    div_i = 8; en_i = 1'b1; tick(3);
    for (int j = 1; j <= 9; j++)
      pv(p2[j-1], p2[j-1] != 8, (j == 4) || (j == 9), (j == 1) ? -1 : p2[j-1]);
    foreach (p2[i]) one_period(p2[i]);
    chk("t2_lock_o", lock_o, 1);
    chk("t2_err_cnt_o", err_cnt_o, 1);
    en_i = 1'b0; tick(3);
    chk("t2_pending", q.size(), 0);

    // Stuck-low input after lock at div 10.
    do_reset();
    div_i = 10; en_i = 1'b1; tick(3);
    for (int j = 1; j <= 5; j++) pv(10, 0, j >= 4, (j == 1) ? -1 : 10);
    pt(11);
    run_calls(10, 6);
    sig_i = 1'b0;
    tick(12);
    chk("t3_state", dut.state, S_ARM);
    chk("t3_lock_o", lock_o, 0);
    chk("t3_err_cnt_o", err_cnt_o, 1);
    chk("t3_pending", q.size(), 0);
    en_i = 1'b0; tick(2);

    // Unmeasurable divisors keep the block idle.
    do_reset();
    en_i = 1'b1;
    foreach (dv[i]) begin
      div_i = W'(dv[i]);
      run_calls(3, 4);
      chk("t4_state", dut.state, S_IDLE);
      chk("t4_lock_o", lock_o, 0);
    end
    chk("t4_pending", q.size(), 0);
    chk("t4_err_cnt_o", err_cnt_o, 0);
    en_i = 1'b0; tick(2);

    // Divisor change 4 -> 6 while locked.
    do_reset();
    div_i = 4; en_i = 1'b1; tick(3);
    for (int j = 1; j <= 4; j++) pv(4, 0, j == 4, (j == 1) ? -1 : 4);
    run_calls(4, 5);
    chk("t5_lock_before", lock_o, 1);
    div_i = 6; tick(2);
    chk("t5_lock_after_change", lock_o, 0);
    chk("t5_state_after_change", dut.state, S_ARM);
    for (int j = 1; j <= 4; j++) pv(6, 0, j == 4, (j == 1) ? -1 : 6);
    run_calls(6, 5);
    chk("t5_relock", lock_o, 1);
    en_i = 1'b0; tick(3);
    chk("t5_pending", q.size(), 0);
    chk("t5_err_cnt_o", err_cnt_o, 0);

    // Reset mid-period, then enable toggled low for 3 cycles.
    do_reset();
    div_i = 5; en_i = 1'b1; tick(3);
    pv(5, 0, 0, -1); pv(5, 0, 0, 5);
    run_calls(5, 3);
    rst_i = 1'b1; tick(2);
    chk("t6_rst_period_o", period_o, 0);
    chk("t6_rst_valid", period_valid_o, 0);
    chk("t6_rst_err_o", err_o, 0);
    chk("t6_rst_timeout_o", timeout_o, 0);
    chk("t6_rst_lock_o", lock_o, 0);
    chk("t6_rst_err_cnt_o", err_cnt_o, 0);
    chk("t6_rst_state", dut.state, S_IDLE);
    rst_i = 1'b0; tick(3);
    for (int j = 1; j <= 3; j++) pv(5, 0, 0, (j == 1) ? -1 : 5);
    run_calls(5, 4);
    en_i = 1'b0; tick(3);
    chk("t6_en_period_hold", period_o, 5);
    chk("t6_en_lock_o", lock_o, 0);
    chk("t6_en_state", dut.state, S_IDLE);
    en_i = 1'b1; tick(3);
    pv(5, 0, 0, -1);
    run_calls(5, 2);
    en_i = 1'b0; tick(3);
    chk("t6_pending", q.size(), 0);
    chk("t6_err_cnt_o", err_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
